// File: rtl/axi_read_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : axi_read_arbiter_pkg
// Brief   : Shared AXI IDs, response codes and arbiter state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axi_read_arbiter_pkg;

  localparam logic [3:0] ArIdInst = 4'h0;
  localparam logic [3:0] ArIdData = 4'h1;
  localparam logic [1:0] RespOkay = 2'b00;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbAddr = 2'd1,
    ArbResp = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_read_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : axi_read_arbiter_if
// Brief   : AXI read address / read data channel bundle (AR + R).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface axi_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);

  logic [ID_W-1:0]   m_arid;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic              m_arvalid;
  logic              m_arready;
  logic [ID_W-1:0]   m_rid;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_arid, m_araddr, m_arlen, m_arsize, m_arvalid, m_rready,
    input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arvalid, m_rready,
    output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
  );

endinterface

`default_nettype wire

// File: rtl/axi_read_arbiter.sv
//------------------------------------------------------------------------------
// Module  : axi_read_arbiter
// Brief   : Shares one AXI read channel between fetch and load, data first.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int ID_W            = 4,
  parameter int MAX_DATA_STREAK = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              flush,
  input  wire logic              inst_req,
  input  wire logic [ADDR_W-1:0] inst_addr,
  output logic                   inst_grant,
  input  wire logic              inst_sink_ready,
  output logic                   inst_valid,
  output logic      [DATA_W-1:0] inst_rdata,
  output logic                   inst_err,
  input  wire logic              data_req,
  input  wire logic [ADDR_W-1:0] data_addr,
  output logic                   data_grant,
  output logic                   data_valid,
  output logic      [DATA_W-1:0] data_rdata,
  output logic                   data_err,
  output logic                   protocol_err,
  axi_read_arbiter_if.master     axi
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  arb_state_t          r_state;
  logic                r_owner_data;
  logic                r_discard;
  logic [STREAK_W-1:0] r_streak;
  logic                r_arvalid;
  logic [ADDR_W-1:0]   r_araddr;
  logic [ID_W-1:0]     r_arid;

  logic w_data_win;
  logic w_inst_win;
  logic w_rready;
  logic w_beat;
  logic w_id_ok;

  // Starvation guard: a full streak with fetch waiting hands one slot to inst.
  assign w_data_win = (r_state == ArbIdle) && data_req &&
                      !(inst_req && (r_streak == STREAK_W'(MAX_DATA_STREAK)));
  assign w_inst_win = (r_state == ArbIdle) && !w_data_win && inst_req && !flush;
  assign w_rready   = (r_state == ArbResp) &&
                      (r_owner_data || inst_sink_ready || r_discard);
  assign w_beat     = w_rready && axi.m_rvalid;
  assign w_id_ok    = (axi.m_rid == r_arid);

  assign inst_grant    = w_inst_win;
  assign data_grant    = w_data_win;
  assign axi.m_arid    = r_arid;
  assign axi.m_araddr  = r_araddr;
  assign axi.m_arlen   = 8'd0;
  assign axi.m_arsize  = 3'b010;
  assign axi.m_arvalid = r_arvalid;
  assign axi.m_rready  = w_rready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ArbIdle;
      r_owner_data <= 1'b0;
      r_discard    <= 1'b0;
      r_streak     <= '0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arid       <= '0;
      inst_valid   <= 1'b0;
      inst_rdata   <= '0;
      inst_err     <= 1'b0;
      data_valid   <= 1'b0;
      data_rdata   <= '0;
      data_err     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
      if (flush && !r_owner_data && (r_state != ArbIdle)) begin
        r_discard <= 1'b1;
      end
      case (r_state)
        ArbIdle: begin
          if (w_data_win) begin
            r_araddr     <= data_addr;
            r_arid       <= ID_W'(ArIdData);
            r_owner_data <= 1'b1;
            r_streak     <= inst_req ? r_streak + STREAK_W'(1) : '0;
            r_arvalid    <= 1'b1;
            r_state      <= ArbAddr;
          end else if (w_inst_win) begin
            r_araddr     <= inst_addr;
            r_arid       <= ID_W'(ArIdInst);
            r_owner_data <= 1'b0;
            r_streak     <= '0;
            r_arvalid    <= 1'b1;
            r_state      <= ArbAddr;
          end
        end
        ArbAddr: begin
          if (axi.m_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= ArbResp;
          end
        end
        ArbResp: begin
          if (w_beat && w_id_ok) begin
            if (r_owner_data) begin
              data_rdata <= axi.m_rdata;
              data_err   <= (axi.m_rresp != RespOkay);
              data_valid <= 1'b1;
            end else begin
              inst_rdata <= axi.m_rdata;
              inst_err   <= (axi.m_rresp != RespOkay);
              // A flush landing on the accept cycle also kills the pulse.
              inst_valid <= !(r_discard || flush);
            end
            r_discard <= 1'b0;
            r_state   <= ArbIdle;
          end else if (w_beat) begin
            protocol_err <= 1'b1;
          end
        end
        default: r_state <= ArbIdle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_axi_read_arbiter
// Brief   : Self-checking bench: vector table, scoreboard, hand corner cases.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_read_arbiter;

  localparam logic [3:0] ID_INST = 4'h0;
  localparam logic [3:0] ID_DATA = 4'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_grant;
  logic        inst_sink_ready;
  logic        inst_valid;
  logic [31:0] inst_rdata;
  logic        inst_err;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_grant;
  logic        data_valid;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        protocol_err;

  always #5 clk = ~clk;

  axi_read_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

  axi_read_arbiter #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .MAX_DATA_STREAK(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_grant(inst_grant),
    .inst_sink_ready(inst_sink_ready), .inst_valid(inst_valid),
    .inst_rdata(inst_rdata), .inst_err(inst_err),
    .data_req(data_req), .data_addr(data_addr), .data_grant(data_grant),
    .data_valid(data_valid), .data_rdata(data_rdata), .data_err(data_err),
    .protocol_err(protocol_err), .axi(axi.master)
  );

  typedef struct {
    logic        is_data;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_dly;
    int          r_dly;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Every valid pulse must match the oldest expected response, in the predicted cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b1 && (inst_valid || data_valid)) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {30'd0, inst_valid, data_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_owner", {30'd0, inst_valid, data_valid}, mon_e.is_data ? 32'd1 : 32'd2);
        chk("sb_rdata", mon_e.is_data ? data_rdata : inst_rdata, mon_e.rdata);
        chk("sb_err", {31'd0, mon_e.is_data ? data_err : inst_err}, {31'd0, mon_e.err});
        chk("sb_latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic want_data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (inst_grant || data_grant) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
    else chk("grant_side", {30'd0, inst_grant, data_grant}, want_data ? 32'd1 : 32'd2);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    step();
    if (v.is_data) begin
      data_req = 1'b1; data_addr = v.addr;
    end else begin
      inst_req = 1'b1; inst_addr = v.addr;
    end
    wait_grant(v.is_data, ok);
    step();
    data_req = 1'b0;
    inst_req = 1'b0;
    if (!ok) return;
    for (int i = 0; i < v.ar_dly; i++) begin
      @(negedge clk);
      chk("arvalid_hold", {31'd0, axi.m_arvalid}, 32'd1);
      step();
    end
    axi.m_arready = 1'b1;
    @(negedge clk);
    chk("araddr", axi.m_araddr, v.addr);
    chk("arid", {28'd0, axi.m_arid}, {28'd0, v.is_data ? ID_DATA : ID_INST});
    step();
    axi.m_arready = 1'b0;
    for (int i = 0; i < v.r_dly; i++) begin
      @(negedge clk);
      chk("arvalid_drop", {31'd0, axi.m_arvalid}, 32'd0);
      step();
    end
    axi.m_rvalid = 1'b1;
    axi.m_rid    = v.is_data ? ID_DATA : ID_INST;
    axi.m_rdata  = v.rdata;
    axi.m_rresp  = v.rresp;
    sb.push_back('{v.is_data, v.exp_rdata, v.exp_err, cyc + 1});
    @(negedge clk);
    chk("rready", {31'd0, axi.m_rready}, 32'd1);
    step();
    axi.m_rvalid = 1'b0;
    @(negedge clk);
  endtask

  vec_t        vecs[6];
  logic [9:0]  exp_order;
  logic [3:0]  seen_id;
  logic        gd;
  bit          ok;
  bit          got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          data  addr          rdata         resp   ar r  exp_rdata     err
    vecs[0] = '{1'b1, 32'h8000_0010, 32'h1234_5678, 2'b00, 0, 0, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b0, 32'hBFC0_0000, 32'h2402_0001, 2'b00, 1, 2, 32'h2402_0001, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 2'b10, 0, 1, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'hCAFE_F00D, 2'b11, 2, 0, 32'hCAFE_F00D, 1'b1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 2'b01, 3, 3, 32'hA5A5_5A5A, 1'b1};
    vecs[5] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 2'b00, 0, 0, 32'h0000_0000, 1'b0};

    rst = 1'b0; flush = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    inst_addr = '0; data_addr = '0; inst_sink_ready = 1'b1;
    axi.m_arready = 1'b0; axi.m_rid = '0; axi.m_rdata = '0;
    axi.m_rresp = '0; axi.m_rlast = 1'b1; axi.m_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_arvalid", {31'd0, axi.m_arvalid}, 32'd0);
    chk("rst_rready", {31'd0, axi.m_rready}, 32'd0);
    chk("rst_grants", {30'd0, inst_grant, data_grant}, 32'd0);
    chk("rst_valids", {30'd0, inst_valid, data_valid}, 32'd0);
    chk("rst_errs", {29'd0, inst_err, data_err, protocol_err}, 32'd0);
    chk("rst_araddr", axi.m_araddr, 32'd0);
    chk("rst_arid", {28'd0, axi.m_arid}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("arlen", {24'd0, axi.m_arlen}, 32'd0);
    chk("arsize", {29'd0, axi.m_arsize}, 32'd2);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both requesters held: D,D,D,D,I,D,D,D,D,I
    exp_order = 10'b01111_01111;
    step();
    inst_req = 1'b1; inst_addr = 32'h0000_0200;
    data_req = 1'b1; data_addr = 32'h0000_0300;
    for (int i = 0; i < 10; i++) begin
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (inst_grant || data_grant) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        chk("streak_timeout", 32'd0, 32'd1);
        break;
      end
      gd = data_grant;
      chk("streak_order", {31'd0, gd}, {31'd0, exp_order[i]});
      step();
      if (i == 9) begin
        inst_req = 1'b0; data_req = 1'b0;
      end
      axi.m_arready = 1'b1;
      @(negedge clk);
      seen_id = axi.m_arid;
      step();
      axi.m_arready = 1'b0;
      axi.m_rvalid = 1'b1; axi.m_rid = seen_id;
      axi.m_rdata = 32'h5000_0000 + i; axi.m_rresp = 2'b00;
      sb.push_back('{gd, 32'h5000_0000 + i, 1'b0, cyc + 1});
      step();
      axi.m_rvalid = 1'b0;
    end
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);

    // Flush in IDLE blocks a fetch grant
    step();
    inst_req = 1'b1; inst_addr = 32'h0000_0500; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_nogrant", {31'd0, inst_grant}, 32'd0);
    step();
    inst_req = 1'b0; flush = 1'b0;

    // Flush while the fetch is in ADDR: response is drained, never delivered
    step();
    inst_sink_ready = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    wait_grant(1'b0, ok);
    step();
    inst_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_arvalid", {31'd0, axi.m_arvalid}, 32'd1);
    step();
    flush = 1'b0; axi.m_arready = 1'b1;
    step();
    axi.m_arready = 1'b0;
    axi.m_rvalid = 1'b1; axi.m_rid = ID_INST; axi.m_rdata = 32'h2402_0001; axi.m_rresp = 2'b00;
    @(negedge clk);
    chk("flush_rready", {31'd0, axi.m_rready}, 32'd1);
    step();
    axi.m_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush_no_valid", {31'd0, inst_valid}, 32'd0);
      step();
    end
    inst_sink_ready = 1'b1;
    run_vec('{1'b0, 32'h0000_0040, 32'h0000_0013, 2'b00, 0, 0, 32'h0000_0013, 1'b0});

    // Fetch response back-pressured by the sink for 3 cycles
    step();
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    wait_grant(1'b0, ok);
    step();
    inst_req = 1'b0; axi.m_arready = 1'b1;
    step();
    axi.m_arready = 1'b0; inst_sink_ready = 1'b0;
    axi.m_rvalid = 1'b1; axi.m_rid = ID_INST; axi.m_rdata = 32'h1111_2222; axi.m_rresp = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rready_low", {31'd0, axi.m_rready}, 32'd0);
      step();
    end
    inst_sink_ready = 1'b1;
    sb.push_back('{1'b0, 32'h1111_2222, 1'b0, cyc + 1});
    @(negedge clk);
    chk("bp_rready_high", {31'd0, axi.m_rready}, 32'd1);
    step();
    axi.m_rvalid = 1'b0;
    @(negedge clk);

    // Wrong rid: beat dropped, sticky protocol error, correct rid still completes
    step();
    data_req = 1'b1; data_addr = 32'h0000_2000;
    wait_grant(1'b1, ok);
    step();
    data_req = 1'b0; axi.m_arready = 1'b1;
    step();
    axi.m_arready = 1'b0;
    axi.m_rvalid = 1'b1; axi.m_rid = 4'h3; axi.m_rdata = 32'hBAD0_BAD0; axi.m_rresp = 2'b00;
    @(negedge clk);
    chk("perr_rready", {31'd0, axi.m_rready}, 32'd1);
    step();
    axi.m_rid = ID_DATA; axi.m_rdata = 32'h7777_0000;
    sb.push_back('{1'b1, 32'h7777_0000, 1'b0, cyc + 1});
    @(negedge clk);
    chk("perr_set", {31'd0, protocol_err}, 32'd1);
    step();
    axi.m_rvalid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("perr_sticky", {31'd0, protocol_err}, 32'd1);

    // Reset while in RESP abandons the transaction
    step();
    data_req = 1'b1; data_addr = 32'h0000_3000;
    wait_grant(1'b1, ok);
    step();
    data_req = 1'b0; axi.m_arready = 1'b1;
    step();
    axi.m_arready = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_arvalid", {31'd0, axi.m_arvalid}, 32'd0);
    chk("mrst_rready", {31'd0, axi.m_rready}, 32'd0);
    chk("mrst_valids", {30'd0, inst_valid, data_valid}, 32'd0);
    chk("mrst_perr", {31'd0, protocol_err}, 32'd0);
    chk("mrst_data_rdata", data_rdata, 32'd0);
    run_vec(vecs[0]);

    repeat (2) step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
